// File: rtl/dff_bank_arbiter.sv
// Two-writer round-robin arbiter in front of one shared WIDTH-bit D-flip-flop register.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (writer 0 always wins).
module dff_bank_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [1:0]       Req,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    output logic [1:0]       Gnt,
    output logic [1:0]       Ack,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic [7:0]       LoadCnt
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StAck  = 2'd2
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_owner;
    logic             w_pick;
    logic [WIDTH-1:0] r_q;
    logic [7:0]       r_load_cnt;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        w_pick = ~Req[0];
    end
`else
    logic r_last;

    // On a conflict the writer that was not served last wins.
    always_comb begin
        w_pick = 1'b0;
        case (Req)
            2'b10:   w_pick = 1'b1;
            2'b11:   w_pick = ~r_last;
            default: w_pick = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_last <= 1'b1;
        end else if (r_state == StLoad) begin
            r_last <= r_owner;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  w_state_next = (Req != 2'b00) ? StLoad : StIdle;
            StLoad:  w_state_next = StAck;
            StAck:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_owner    <= 1'b0;
            r_q        <= '0;
            r_load_cnt <= 8'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (Req != 2'b00) begin
                        r_owner <= w_pick;
                    end
                end
                StLoad:  r_q <= r_owner ? D1 : D0;
                StAck:   r_load_cnt <= r_load_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        Gnt = 2'b00;
        Ack = 2'b00;
        case (r_state)
            StLoad:  Gnt = r_owner ? 2'b10 : 2'b01;
            StAck:   Ack = r_owner ? 2'b10 : 2'b01;
            default: ;
        endcase
        Busy    = (r_state != StIdle);
        Q       = r_q;
        LoadCnt = r_load_cnt;
    end

endmodule
